// File: rtl/lsu_mem.sv
// lsu_mem: load/store unit between the core and a word-wide synchronous RAM.
// Turns RV32I byte/halfword/word loads and stores into whole-word RAM
// accesses. Sub-word stores use read-modify-write, and loads are sign- or
// zero-extended. The core is stalled through `ready` while a two-cycle
// access is in flight.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   daddr, ddata_w        core byte address and right-aligned store data
//   MemRead, MemWrite     core load / store request (store wins if both)
//   funct3                access size/sign (RV32I encoding)
//   ddata_r, ready, err   extended load data, completion, error pulse
//   ram_address, ram_data RAM word address and write data
//   ram_wren, ram_rden    RAM write / read strobes
//   ram_q                 RAM read data, valid one cycle after ram_rden
module lsu_mem #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          daddr,
  input  logic [31:0]          ddata_w,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [2:0]           funct3,
  output logic [31:0]          ddata_r,
  output logic                 ready,
  output logic                 err,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [31:0]          ram_data,
  output logic                 ram_wren,
  output logic                 ram_rden,
  input  logic [31:0]          ram_q
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_MERGE} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] addr_p0;
  logic [1:0]           off_p0;
  logic [2:0]           f3_p0;
  logic [15:0]          wdata_p0;
  logic                 req, bad, accept;

  // Upper address bits wrap modulo the RAM size.
  logic unused_addr;
  assign unused_addr = ^daddr[31:ADDR_BITS+2];

  // Misaligned or illegal-encoding access.
  function automatic logic bad_access(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic b;
    case (f3)
      3'b000:  b = 1'b0;
      3'b001:  b = off[0];
      3'b010:  b = (off != 2'b00);
      3'b100:  b = is_store;
      3'b101:  b = is_store | off[0];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  // Lane select plus sign/zero extension of a loaded word.
  function automatic logic [31:0] load_extend(input logic [31:0] q, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = q[{off, 3'b000} +: 8];
    h = q[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  v = {{24{b[7]}}, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b100:  v = {24'h000000, b};
      3'b101:  v = {16'h0000, h};
      default: v = q;
    endcase
    return v;
  endfunction

  // Replace the addressed byte or halfword of the old word.
  function automatic logic [31:0] merge_word(input logic [31:0] q, input logic [15:0] d,
                                             input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] m;
    m = q;
    if (f3[1:0] == 2'b00)
      m[{off, 3'b000} +: 8] = d[7:0];
    else
      m[{off[1], 4'b0000} +: 16] = d;
    return m;
  endfunction

  assign req    = MemRead | MemWrite;
  assign bad    = bad_access(MemWrite, funct3, daddr[1:0]);
  assign accept = (state == IDLE) && (state_nxt != IDLE);

  // State register and request latches
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      addr_p0  <= '0;
      off_p0   <= 2'b00;
      f3_p0    <= 3'b000;
      wdata_p0 <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_p0 <= daddr[ADDR_BITS+1:2];
        off_p0  <= daddr[1:0];
        f3_p0   <= funct3;
        if (MemWrite)
          wdata_p0 <= ddata_w[15:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req && !bad) begin
          if (MemWrite)
            state_nxt = (funct3 == 3'b010) ? IDLE : RMW_MERGE;
          else
            state_nxt = LOAD_WAIT;
        end
      end
      LOAD_WAIT: state_nxt = IDLE;
      RMW_MERGE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs: all combinational, forced to zero while RESET is high
  always_comb begin
    ddata_r     = 32'h0;
    ready       = 1'b0;
    err         = 1'b0;
    ram_address = '0;
    ram_data    = 32'h0;
    ram_wren    = 1'b0;
    ram_rden    = 1'b0;
    if (!RESET) begin
      case (state)
        IDLE: begin
          ram_address = daddr[ADDR_BITS+1:2];
          if (!req) begin
            ready = 1'b1;
          end else if (bad) begin
            ready = 1'b1;
            err   = 1'b1;
          end else if (MemWrite && funct3 == 3'b010) begin
            ram_wren = 1'b1;
            ram_data = ddata_w;
            ready    = 1'b1;
          end else begin
            ram_rden = 1'b1;
          end
        end
        LOAD_WAIT: begin
          ram_address = addr_p0;
          ddata_r     = load_extend(ram_q, f3_p0, off_p0);
          ready       = 1'b1;
        end
        RMW_MERGE: begin
          ram_address = addr_p0;
          ram_data    = merge_word(ram_q, wdata_p0, f3_p0, off_p0);
          ram_wren    = 1'b1;
          ready       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: testbench for lsu_mem. Holds a word RAM with registered read
// data, and a byte-addressed reference memory from which expected load
// values, error flags and latencies are computed.
module tb_lsu_mem;
  localparam int AB = 10;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [31:0]   daddr = 32'h0;
  logic [31:0]   ddata_w = 32'h0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [2:0]    funct3 = 3'b000;
  logic [31:0]   ddata_r;
  logic          ready;
  logic          err;
  logic [AB-1:0] ram_address;
  logic [31:0]   ram_data;
  logic          ram_wren;
  logic          ram_rden;
  logic [31:0]   ram_q = 32'h0;

  logic [31:0] mem [1024] = '{default: 32'h0};
  logic [7:0]  refmem [4096] = '{default: 8'h0};

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  lsu_mem #(.ADDR_BITS(AB)) dut (
    .CLK(CLK), .RESET(RESET), .daddr(daddr), .ddata_w(ddata_w),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ddata_r(ddata_r), .ready(ready), .err(err),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q)
  );

  always @(posedge CLK) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_address];
  end

  // Reference model: byte-addressed memory
  function automatic logic ref_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic legal;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int idx, sz;
    longint v;
    idx = int'(a % 4096);
    sz = 1 << f3[1:0];
    v = 0;
    for (int k = sz - 1; k >= 0; k--) v = v * 256 + longint'(refmem[idx + k]);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int idx, sz;
    idx = int'(a % 4096);
    sz = 1 << f3[1:0];
    for (int k = 0; k < sz; k++) refmem[idx + k] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  // Drives one request starting just after a rising edge and returns what the
  // DUT did; leaves the inputs in place so the next call is back-to-back.
  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      output int cyc, output logic [31:0] rdata, output logic e,
                      output int nw, output int nr, output logic wren1,
                      output logic [AB-1:0] a1, output logic [31:0] wdat);
    MemRead = rd; MemWrite = wr; funct3 = f3; daddr = a; ddata_w = d;
    cyc = 0; nw = 0; nr = 0; rdata = 32'h0; e = 1'b0; wdat = 32'h0;
    wren1 = 1'b0; a1 = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin wren1 = ram_wren; a1 = ram_address; end
      if (ram_wren) begin nw++; wdat = ram_data; end
      if (ram_rden) nr++;
      if (ready) begin rdata = ddata_r; e = err; break; end
      if (cyc >= 4) begin cyc = 99; break; end
    end
    @(posedge CLK); #1;
  endtask

  task automatic go_idle();
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    MemRead = 1'b1; funct3 = 3'b010; daddr = 32'h10;
    @(negedge CLK);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (ddata_r !== 32'h0) begin bad++; $display("FAIL reset_ddata_r got=%h want=0", ddata_r); end
    total++; if (ram_wren !== 1'b0 || ram_rden !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got=%b%b want=00", ram_wren, ram_rden); end
    total++; if (ram_address !== '0 || ram_data !== 32'h0) begin
      bad++; $display("FAIL reset_ram_bus got=%h/%h want=0/0", ram_address, ram_data); end
    @(posedge CLK); #1;
    RESET = 1'b0; go_idle();
    @(negedge CLK);
    total++; if (ready !== 1'b1 || ram_wren !== 1'b0 || ram_rden !== 1'b0) begin
      bad++; $display("FAIL idle_norequest got=rdy%b wr%b rd%b want=rdy1 wr0 rd0", ready, ram_wren, ram_rden); end
    @(posedge CLK); #1;
  endtask

  task automatic test_sw_lw();
    int cyc, nw, nr; logic [31:0] rdata, wdat; logic e, w1; logic [AB-1:0] a1;
    xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, cyc, rdata, e, nw, nr, w1, a1, wdat);
    ref_store(3'b010, 32'h10, 32'hDEADBEEF);
    total++; if (cyc !== 1 || w1 !== 1'b1 || e !== 1'b0) begin
      bad++; $display("FAIL sw_timing got=cyc%0d wren1=%b err=%b want=cyc1 wren1=1 err=0", cyc, w1, e); end
    total++; if (a1 !== 10'd4 || wdat !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_bus got=%0d/%h want=4/deadbeef", a1, wdat); end
    xact(1, 0, 3'b010, 32'h10, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (cyc !== 2 || rdata !== 32'hDEADBEEF || nw !== 0) begin
      bad++; $display("FAIL lw got=cyc%0d data=%h nw=%0d want=cyc2 data=deadbeef nw=0", cyc, rdata, nw); end
    go_idle();
  endtask

  task automatic test_subword();
    int cyc, nw, nr; logic [31:0] rdata, wdat; logic e, w1; logic [AB-1:0] a1;
    xact(0, 1, 3'b010, 32'h10, 32'h11223344, cyc, rdata, e, nw, nr, w1, a1, wdat);
    ref_store(3'b010, 32'h10, 32'h11223344);
    xact(0, 1, 3'b000, 32'h13, 32'h00000080, cyc, rdata, e, nw, nr, w1, a1, wdat);
    ref_store(3'b000, 32'h13, 32'h80);
    total++; if (cyc !== 2 || w1 !== 1'b0 || nw !== 1 || wdat !== 32'h80223344) begin
      bad++; $display("FAIL sb_rmw got=cyc%0d wren1=%b nw=%0d data=%h want=cyc2 wren1=0 nw=1 data=80223344",
                      cyc, w1, nw, wdat); end
    xact(1, 0, 3'b000, 32'h13, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h want=ffffff80", rdata); end
    xact(1, 0, 3'b100, 32'h13, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (rdata !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h want=00000080", rdata); end
    xact(0, 1, 3'b010, 32'h10, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    ref_store(3'b010, 32'h10, 32'h0);
    xact(0, 1, 3'b001, 32'h12, 32'h0000A5A5, cyc, rdata, e, nw, nr, w1, a1, wdat);
    ref_store(3'b001, 32'h12, 32'hA5A5);
    total++; if (cyc !== 2 || wdat !== 32'hA5A50000) begin
      bad++; $display("FAIL sh_rmw got=cyc%0d data=%h want=cyc2 data=a5a50000", cyc, wdat); end
    xact(1, 0, 3'b001, 32'h12, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (rdata !== 32'hFFFFA5A5) begin bad++; $display("FAIL lh got=%h want=ffffa5a5", rdata); end
    xact(1, 0, 3'b101, 32'h12, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (rdata !== 32'h0000A5A5) begin bad++; $display("FAIL lhu got=%h want=0000a5a5", rdata); end
    go_idle();
  endtask

  task automatic test_errors();
    int cyc, nw, nr; logic [31:0] rdata, wdat; logic e, w1; logic [AB-1:0] a1;
    logic        t_rd [3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0]  t_f3 [3] = '{3'b010, 3'b001, 3'b100};
    logic [31:0] t_a  [3] = '{32'h6, 32'h5, 32'h10};
    for (int i = 0; i < 3; i++) begin
      xact(t_rd[i], !t_rd[i], t_f3[i], t_a[i], 32'hFFFFFFFF, cyc, rdata, e, nw, nr, w1, a1, wdat);
      total++; if (cyc !== 1 || e !== 1'b1 || nw !== 0 || nr !== 0) begin
        bad++; $display("FAIL err_case%0d got=cyc%0d err=%b nw=%0d nr=%0d want=cyc1 err=1 nw=0 nr=0",
                        i, cyc, e, nw, nr); end
    end
    xact(1, 0, 3'b010, 32'h10, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (rdata !== ref_load(3'b010, 32'h10)) begin
      bad++; $display("FAIL err_ram_unchanged got=%h want=%h", rdata, ref_load(3'b010, 32'h10)); end
    xact(1, 0, 3'b010, 32'h4, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (rdata !== ref_load(3'b010, 32'h4)) begin
      bad++; $display("FAIL err_word1_unchanged got=%h want=%h", rdata, ref_load(3'b010, 32'h4)); end
    go_idle();
  endtask

  task automatic test_reset_abort();
    int cyc, nw, nr; logic [31:0] rdata, wdat; logic e, w1; logic [AB-1:0] a1;
    xact(0, 1, 3'b010, 32'h30, 32'h12345678, cyc, rdata, e, nw, nr, w1, a1, wdat);
    ref_store(3'b010, 32'h30, 32'h12345678);
    MemWrite = 1'b1; MemRead = 1'b0; funct3 = 3'b000; daddr = 32'h31; ddata_w = 32'hAA;
    @(negedge CLK);
    total++; if (ram_rden !== 1'b1 || ready !== 1'b0) begin
      bad++; $display("FAIL abort_first got=rden%b rdy%b want=rden1 rdy0", ram_rden, ready); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    total++; if (ram_wren !== 1'b0 || ready !== 1'b0 || ram_data !== 32'h0 || ram_address !== '0) begin
      bad++; $display("FAIL abort_outputs got=wren%b rdy%b data=%h addr=%h want=all0",
                      ram_wren, ready, ram_data, ram_address); end
    @(posedge CLK); #1;
    RESET = 1'b0; go_idle();
    xact(1, 0, 3'b010, 32'h30, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (rdata !== 32'h12345678) begin
      bad++; $display("FAIL abort_ram_unchanged got=%h want=12345678", rdata); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int cyc, nw, nr; logic [31:0] rdata, wdat; logic e, w1; logic [AB-1:0] a1;
    xact(1, 1, 3'b010, 32'h20, 32'h00000055, cyc, rdata, e, nw, nr, w1, a1, wdat);
    ref_store(3'b010, 32'h20, 32'h55);
    total++; if (cyc !== 1 || nw !== 1 || nr !== 0) begin
      bad++; $display("FAIL both_write_only got=cyc%0d nw=%0d nr=%0d want=cyc1 nw=1 nr=0", cyc, nw, nr); end
    xact(1, 0, 3'b010, 32'h20, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
    total++; if (rdata !== 32'h00000055) begin bad++; $display("FAIL both_readback got=%h want=00000055", rdata); end
    for (int r = 0; r < 3; r++) begin
      logic [31:0] a, d;
      a = 32'h40 + 32'(r * 4); d = $urandom;
      xact(0, 1, 3'b010, a, d, cyc, rdata, e, nw, nr, w1, a1, wdat);
      ref_store(3'b010, a, d);
      total++; if (cyc !== 1) begin bad++; $display("FAIL b2b_sw_cycles got=%0d want=1", cyc); end
      xact(1, 0, 3'b010, a, 32'h0, cyc, rdata, e, nw, nr, w1, a1, wdat);
      total++; if (cyc !== 2 || rdata !== ref_load(3'b010, a)) begin
        bad++; $display("FAIL b2b_lw got=cyc%0d data=%h want=cyc2 data=%h", cyc, rdata, ref_load(3'b010, a)); end
      xact(0, 1, 3'b000, a + 1, d ^ 32'h5A, cyc, rdata, e, nw, nr, w1, a1, wdat);
      ref_store(3'b000, a + 1, d ^ 32'h5A);
      total++; if (cyc !== 2 || wdat !== ref_load(3'b010, a)) begin
        bad++; $display("FAIL b2b_sb got=cyc%0d data=%h want=cyc2 data=%h", cyc, wdat, ref_load(3'b010, a)); end
    end
    go_idle();
  endtask

  task automatic test_random();
    int cyc, nw, nr, ecyc, enw; logic [31:0] rdata, wdat, edata; logic e, ee, w1; logic [AB-1:0] a1;
    for (int i = 0; i < 200; i++) begin
      logic st, rd; logic [2:0] f3; logic [31:0] a, d;
      st = 1'($urandom_range(0, 1));
      rd = st ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom & 32'hFFFFF07F;
      d  = $urandom;
      ee = ref_err(st, f3, a);
      ecyc = (ee || (st && f3 == 3'd2)) ? 1 : 2;
      enw = (st && !ee) ? 1 : 0;
      edata = (!st && !ee) ? ref_load(f3, a) : 32'h0;
      xact(rd, st, f3, a, d, cyc, rdata, e, nw, nr, w1, a1, wdat);
      if (st && !ee) ref_store(f3, a, d);
      total++; if (cyc !== ecyc || e !== ee || nw !== enw || rdata !== edata) begin
        bad++; $display("FAIL rand%0d st=%b f3=%0d a=%h got=cyc%0d err=%b nw=%0d data=%h want=cyc%0d err=%b nw=%0d data=%h",
                        i, st, f3, a, cyc, e, nw, rdata, ecyc, ee, enw, edata); end
      if ($urandom_range(0, 3) == 0) begin go_idle(); @(posedge CLK); #1; end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_subword();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem.md
# lsu_mem

Load/store unit between `core` and the word-wide data `RAM`. It turns the core's byte, halfword and word loads/stores (RV32I funct3 encoding) into whole-word RAM accesses. Sub-word stores use a read-modify-write sequence, and load data is sign- or zero-extended. The unit stalls the core through `ready` while a multi-cycle access is in flight.

## Interface
- Parameters
  - `ADDR_BITS`, default 10: RAM word-address width; RAM address is `daddr[ADDR_BITS+1:2]`.
- Ports
  - `CLK` in 1: single clock. All state updates on the rising edge.
  - `RESET` in 1: reset, synchronous and active-high.
  - `daddr` in 32: byte address from the core.
  - `ddata_w` in 32: store data from the core, right-aligned.
  - `MemRead` in 1: load request.
  - `MemWrite` in 1: store request.
  - `funct3` in 3: access size/sign.
    - 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
  - `ddata_r` out 32: extended load data. Valid only in the cycle where `ready`=1 for a load, else 0.
  - `ready` out 1: request completes this cycle; the core must hold its request stable until `ready`=1.
  - `err` out 1: one-cycle pulse with `ready` on a misaligned access or illegal funct3.
  - `ram_address` out ADDR_BITS: RAM word address.
  - `ram_data` out 32: RAM write data.
  - `ram_wren` out 1: RAM write enable.
  - `ram_rden` out 1: RAM read enable.
  - `ram_q` in 32: RAM read data, registered, valid one cycle after `ram_rden`.

## Operation
- FSM states:
  - IDLE
  - LOAD_WAIT
  - RMW_MERGE
- IDLE handling, by request:
  - No request: `ready`=1, all RAM strobes 0.
  - `MemWrite`=1: takes priority when `MemRead` is also 1.
  - Check first: misaligned access (H with `daddr[0]`=1, W with `daddr[1:0]`≠0) or illegal funct3 (011, 110, 111; 100/101 on a store). Response: `ready`=1, `err`=1, no RAM strobe, stay IDLE.
  - SW: `ram_wren`=1, `ram_data`=`ddata_w`, `ready`=1, stay IDLE. Zero wait states.
  - SB/SH: `ram_rden`=1. Latch address, funct3 and `ddata_w`. `ready`=0. Go to RMW_MERGE.
  - Load: `ram_rden`=1. Latch address and funct3. `ready`=0. Go to LOAD_WAIT.
- LOAD_WAIT:
  - Select the lane of `ram_q` by latched `addr[1:0]` (B) or `addr[1]` (H). Little-endian: byte 0 = bits [7:0].
  - Extend to 32 bits: sign-extend for B/H, zero-extend for BU/HU.
  - Drive `ddata_r`, `ready`=1, go to IDLE.
- RMW_MERGE:
  - Merge: replace the addressed byte or halfword of `ram_q` with `ddata_w[7:0]` or `ddata_w[15:0]`.
  - Drive the merged word on `ram_data`, `ram_wren`=1, `ram_address`=latched address, `ready`=1, go to IDLE.
- `ram_address` source: `daddr` slice in IDLE, latched address in the other states.
- Address bits above ADDR_BITS+1 are ignored (wrap modulo RAM size).
- Inputs are not re-sampled in LOAD_WAIT/RMW_MERGE. A request change during a stall is ignored until IDLE.

## Timing
- Reset (in the cycle `RESET`=1, and the next edge):
  - State goes to IDLE. Latches clear to 0.
  - `ready`=0, `err`=0, `ddata_r`=0, `ram_wren`=0, `ram_rden`=0, `ram_address`=0, `ram_data`=0.
  - `RESET` asserted during LOAD_WAIT or RMW_MERGE aborts the access. No RAM write is issued in that cycle or after.
- Latency from the request cycle:
  - SW and error cases: 0 extra cycles, `ready` in the same cycle.
  - All loads, SB, SH: 1 extra cycle, `ready` in the second cycle.
- Back-to-back requests: a new request is accepted in the cycle after `ready`. Sustained throughput:
  - SW: 1 access/cycle.
  - Loads and sub-word stores: 1 access per 2 cycles.
- Outputs `ready`, `ddata_r`, `err` and the RAM strobes are combinational from state, inputs and `ram_q`. There is no registered output delay.

## Test plan
- Reset then SW: 0xDEADBEEF to 0x010. Expect `ram_wren` in the same cycle, `ram_address`=4, `ready`=1. Then LW 0x010: `ready` on the 2nd cycle, `ddata_r`=0xDEADBEEF.
- SB 0x80 to 0x013 over word 0x11223344. Expect 2nd-cycle write 0x80223344. LB 0x013 gives 0xFFFFFF80; LBU 0x013 gives 0x00000080.
- SH 0xA5A5 to 0x012 over word 0x00000000, gives 0xA5A50000. LH 0x012 gives 0xFFFFA5A5; LHU 0x012 gives 0x0000A5A5.
- Misaligned LW 0x006, SH 0x005 and store funct3=100: each returns `err`=1 and `ready`=1 in the same cycle, with no `ram_wren`/`ram_rden` and RAM contents unchanged.
- Issue SB, assert `RESET` in the RMW_MERGE cycle. Expect no `ram_wren`, target word unchanged, outputs at reset values.
- `MemRead`=`MemWrite`=1 with SW 0x00000055 to 0x020. Expect a write only, and LW 0x020 returns 0x00000055. Then interleave SW/LW/SB in consecutive cycles. Expect cycle counts of 1, 2 and 2 respectively.
